pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the hold (stall) and bubble (flush) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates between these hazard sources: multi-cycle instruction-memory and data-memory handshakes, load-use hazards, taken branches/jumps resolved in EX, and halt draining.

Parameters:
- REG_W, 3: register-specifier width.
- CNT_W, 16: width of the watchdog and performance counters.
- DWAIT_MAX, 64: maximum data-memory wait cycles before err is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifid_rs, ifid_rt  in  REG_W  source registers of the instruction in ID
- ifid_rs_used, ifid_rt_used  in  1  qualify the source fields
- idex_memread  in  1  instruction in EX is a load
- idex_wr_reg  in  REG_W  destination of the instruction in EX
- br_taken_ex  in  1  redirect resolved in EX
- halt_id  in  1  halt decoded in ID
- halt_wb  in  1  halt present in MEM/WB
- imem_stall, imem_done  in  1  fetch-memory handshake
- dmem_req  in  1  EX/MEM holds a load/store
- dmem_stall, dmem_done  in  1  data-memory handshake
- stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb  out  1  register hold enables (active-high)
- flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1  bubble insertion
- fetch_discard  out  1  drop the returning fetch word
- halted  out  1  processor stopped
- err  out  1  sticky protocol/watchdog error

Behaviour:
- Reset: state=RUN; every stall_*, flush_*, fetch_discard, halted and err output is 0; all counters are 0.
- Stall and flush are never both asserted for the same register in the same cycle.
- States: RUN, DWAIT, IWAIT, IDISCARD, DRAIN, HALTED.
- RUN, combinational priority:
  - 1. dmem_req & dmem_stall: assert stall_pc/ifid/idex/exmem and flush_memwb. Next state DWAIT, dwait counter cleared.
  - 2. br_taken_ex: assert flush_ifid and flush_idex; PC not stalled. If imem_stall is also high, next state IDISCARD.
  - 3. Load-use: idex_memread & ((ifid_rs_used & rs==idex_wr_reg) | (ifid_rt_used & rt==idex_wr_reg)). Assert stall_pc and stall_ifid, flush_idex. Single cycle.
  - 4. imem_stall: assert stall_pc and flush_ifid. Next state IWAIT.
  - 5. halt_id (with no higher-priority event): assert stall_pc and flush_ifid. Next state DRAIN.
- DWAIT: keep the priority-1 outputs. The dwait counter increments each cycle. On dmem_done, release (outputs 0 that cycle) and go to RUN. If the counter reaches DWAIT_MAX: set err, stay in DWAIT.
- While in DWAIT, br_taken_ex is ignored. The EX stage is frozen, so the branch is re-evaluated after DWAIT exits.
- IWAIT: stall_pc, flush_ifid.
  - On imem_done: go to RUN; the fetch word is accepted.
  - br_taken_ex in IWAIT: flush_idex, go to IDISCARD.
  - dmem stall in IWAIT takes precedence: DWAIT outputs apply, and a return to IWAIT is remembered in a 1-bit flag.
- IDISCARD: stall_pc, flush_ifid, fetch_discard=1 until imem_done, then RUN. The PC loads the redirect target on the IDISCARD->RUN transition cycle.
- DRAIN: stall_pc and flush_ifid every cycle. Data stalls still honoured as in DWAIT. On halt_wb, go to HALTED.
- HALTED: all stall_* = 1, halted = 1. Only rst exits.
- err is sticky until rst. It is set by:
  - dmem_done when state is not DWAIT and dmem_stall is low;
  - imem_done in RUN or DRAIN;
  - the watchdog expiring.
- Reset mid-operation: returns to RUN next cycle; no output glitches beyond the reset values.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- When defined, three extra CNT_W-bit outputs are added:
  - perf_stall_cyc: cycles with stall_pc=1 outside HALTED;
  - perf_flush_cnt: br_taken_ex flush events;
  - perf_lu_cnt: load-use bubbles.
- All three saturate at all-ones and clear on rst.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum;
  - the NOP instruction constant 16'h0800;
  - the REG_W default;
  - the CNT_W default.
- Sub-module load_use_detect: the combinational comparator producing the load-use hazard flag.

Test Plan:
- Load r3, then the next instruction in ID reads rs=3 (rs_used=1) -> one cycle of stall_pc=stall_ifid=1, flush_idex=1, then RUN outputs 0.
- dmem_req=1, dmem_stall high 4 cycles, then dmem_done -> stall_pc..stall_exmem=1 and flush_memwb=1 for exactly 4 cycles, 0 on the done cycle.
- imem_stall=1, br_taken_ex=1 in the same cycle, imem_done 3 cycles later -> flush_ifid/idex on cycle 0, fetch_discard=1 until done, state back to RUN.
- halt_id=1, halt_wb=1 three cycles later -> flush_ifid for 3 cycles, then halted=1 and all stalls=1 persisting until rst.
- dmem_stall held DWAIT_MAX=64 cycles with no done -> err=1 on cycle 64; err stays 1 after done, clears only on rst.
- dmem_done pulse while in RUN with dmem_stall=0 -> err=1 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t      : sequencer states
//   NopInstr     : encoding of the bubble instruction
//   RegWDefault  : default register-specifier width
//   CntWDefault  : default watchdog / performance counter width
package pipe_ctrl_pkg;

  localparam int unsigned RegWDefault = 3;
  localparam int unsigned CntWDefault = 16;
  localparam logic [15:0] NopInstr    = 16'h0800;

  typedef enum logic [2:0] {
    StRun,
    StDwait,
    StIwait,
    StIdiscard,
    StDrain,
    StHalted
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator.
//   rs, rt           : source registers of the instruction in ID
//   rs_used, rt_used : qualify the source fields
//   memread          : instruction in EX is a load
//   wr_reg           : destination of the instruction in EX
//   hazard           : ID reads the register the EX load is about to write
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = RegWDefault
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             memread,
  input  logic [REG_W-1:0] wr_reg,
  output logic             hazard
);

  assign hazard = memread & ((rs_used & (rs == wr_reg)) | (rt_used & (rt == wr_reg)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Inputs : ID source registers/qualifiers, EX load info, EX redirect, halt in ID/WB,
//          instruction- and data-memory handshakes.
// Outputs: hold enables (stall_*) and bubble inserts (flush_*) for PC, IF/ID, ID/EX,
//          EX/MEM, MEM/WB; fetch_discard, halted, sticky err.
// Optional: define PIPE_CTRL_PERF_CNT_EN to add perf_stall_cyc, perf_flush_cnt and
//           perf_lu_cnt saturating counters.
// All combinational outputs read 0 while rst is high.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W     = RegWDefault,
  parameter int unsigned CNT_W     = CntWDefault,
  parameter int unsigned DWAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_rs_used,
  input  logic             ifid_rt_used,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_wr_reg,
  input  logic             br_taken_ex,
  input  logic             halt_id,
  input  logic             halt_wb,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             dmem_req,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             fetch_discard,
  output logic             halted,
  output logic             err
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_lu_cnt
`endif
);

  localparam logic [CNT_W-1:0] DwaitMax  = CNT_W'(DWAIT_MAX);
  localparam logic [CNT_W-1:0] DwaitLast = CNT_W'(DWAIT_MAX - 1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;     // state to resume once the data stall ends
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             err_q, err_d;
  logic             lu_hazard;
  logic             dstall;

  assign dstall = dmem_req & dmem_stall;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use_detect (
    .rs      (ifid_rs),
    .rt      (ifid_rt),
    .rs_used (ifid_rs_used),
    .rt_used (ifid_rt_used),
    .memread (idex_memread),
    .wr_reg  (idex_wr_reg),
    .hazard  (lu_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      ret_q   <= StRun;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      StRun: begin
        if (dstall) begin
          state_d = StDwait;
          ret_d   = StRun;
          dcnt_d  = '0;
        end else if (br_taken_ex) begin
          if (imem_stall) state_d = StIdiscard;
        end else if (lu_hazard) begin
          state_d = StRun;
        end else if (imem_stall) begin
          state_d = StIwait;
        end else if (halt_id) begin
          state_d = StDrain;
        end
      end
      StDwait: begin
        // EX is frozen here, so a pending branch is seen again after release
        if (dmem_done) state_d = ret_q;
        else if (dcnt_q != DwaitMax) dcnt_d = dcnt_q + CNT_W'(1);
      end
      StIwait: begin
        if (dstall) begin
          state_d = StDwait;
          ret_d   = StIwait;
          dcnt_d  = '0;
        end else if (br_taken_ex) begin
          state_d = imem_done ? StRun : StIdiscard;
        end else if (imem_done) begin
          state_d = StRun;
        end
      end
      StIdiscard: begin
        if (dstall) begin
          state_d = StDwait;
          ret_d   = StIdiscard;
          dcnt_d  = '0;
        end else if (imem_done) begin
          state_d = StRun;
        end
      end
      StDrain: begin
        if (dstall) begin
          state_d = StDwait;
          ret_d   = StDrain;
          dcnt_d  = '0;
        end else if (halt_wb) begin
          state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase

    err_d = err_q
          | (dmem_done & ~dmem_stall & (state_q != StDwait))
          | (imem_done & ((state_q == StRun) | (state_q == StDrain)))
          | ((state_q == StDwait) & ~dmem_done & (dcnt_q == DwaitLast));
  end

  always_comb begin
    stall_pc      = 1'b0;
    stall_ifid    = 1'b0;
    stall_idex    = 1'b0;
    stall_exmem   = 1'b0;
    stall_memwb   = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    flush_memwb   = 1'b0;
    fetch_discard = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (dstall) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_memwb} = 5'b11111;
          end else if (br_taken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (lu_hazard) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (imem_stall || halt_id) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
          end
        end
        StDwait: begin
          if (!dmem_done) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_memwb} = 5'b11111;
          end
        end
        StIwait: begin
          if (dstall) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_memwb} = 5'b11111;
          end else if (br_taken_ex) begin
            // Word arriving now is wrong-path; drop it and let the PC redirect
            flush_ifid    = 1'b1;
            flush_idex    = 1'b1;
            fetch_discard = imem_done;
            stall_pc      = ~imem_done;
          end else if (!imem_done) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
          end
        end
        StIdiscard: begin
          if (dstall) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_memwb} = 5'b11111;
          end else begin
            flush_ifid    = 1'b1;
            fetch_discard = 1'b1;
            stall_pc      = ~imem_done;  // PC takes the redirect target on the done cycle
          end
        end
        StDrain: begin
          if (dstall) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_memwb} = 5'b11111;
          end else if (halt_wb) begin
            {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = 5'b11111;
            halted = 1'b1;
          end else begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
          end
        end
        StHalted: begin
          {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = 5'b11111;
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err = err_q & ~rst;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] pstall_q, pflush_q, plu_q;
  logic             br_ev, lu_ev;

  assign br_ev = ~dstall & br_taken_ex & ((state_q == StRun) | (state_q == StIwait));
  assign lu_ev = (state_q == StRun) & ~dstall & ~br_taken_ex & lu_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
      plu_q    <= '0;
    end else begin
      if (stall_pc && state_q != StHalted && pstall_q != '1) pstall_q <= pstall_q + CNT_W'(1);
      if (br_ev && pflush_q != '1) pflush_q <= pflush_q + CNT_W'(1);
      if (lu_ev && plu_q != '1) plu_q <= plu_q + CNT_W'(1);
    end
  end

  assign perf_stall_cyc = pstall_q;
  assign perf_flush_cnt = pflush_q;
  assign perf_lu_cnt    = plu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  // Stimulus bits of in_vec
  localparam logic [11:0] I_BR  = 12'h001;
  localparam logic [11:0] I_HID = 12'h002;
  localparam logic [11:0] I_HWB = 12'h004;
  localparam logic [11:0] I_IST = 12'h008;
  localparam logic [11:0] I_IDN = 12'h010;
  localparam logic [11:0] I_DRQ = 12'h020;
  localparam logic [11:0] I_DST = 12'h040;
  localparam logic [11:0] I_DDN = 12'h080;
  localparam logic [11:0] I_MR  = 12'h100;
  localparam logic [11:0] I_RSU = 12'h200;
  localparam logic [11:0] I_RTU = 12'h400;
  localparam logic [11:0] I_RST = 12'h800;

  // Observed vector: {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
  //                   flush_ifid, flush_idex, flush_exmem, flush_memwb,
  //                   fetch_discard, halted, err}
  localparam logic [11:0] O_0    = 12'b0000_0000_0000;
  localparam logic [11:0] O_DW   = 12'b1111_0000_1000;
  localparam logic [11:0] O_LU   = 12'b1100_0010_0000;
  localparam logic [11:0] O_BR   = 12'b0000_0110_0000;
  localparam logic [11:0] O_BRW  = 12'b1000_0110_0000;
  localparam logic [11:0] O_IF   = 12'b1000_0100_0000;
  localparam logic [11:0] O_ID   = 12'b1000_0100_0100;
  localparam logic [11:0] O_IDX  = 12'b0000_0100_0100;
  localparam logic [11:0] O_HALT = 12'b1111_1000_0010;
  localparam logic [11:0] O_ERR  = 12'b0000_0000_0001;

  typedef struct {
    logic [11:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic [11:0] in_vec = I_RST;
  logic [2:0]  rs_r = '0, rt_r = '0, wr_r = '0;

  logic stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic fetch_discard, halted, err;
  logic [11:0] obs;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [15:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

  always #5 clk = ~clk;

  assign obs = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb, flush_ifid,
                flush_idex, flush_exmem, flush_memwb, fetch_discard, halted, err};

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rst           (in_vec[11]),
    .ifid_rs       (rs_r),
    .ifid_rt       (rt_r),
    .ifid_rs_used  (in_vec[9]),
    .ifid_rt_used  (in_vec[10]),
    .idex_memread  (in_vec[8]),
    .idex_wr_reg   (wr_r),
    .br_taken_ex   (in_vec[0]),
    .halt_id       (in_vec[1]),
    .halt_wb       (in_vec[2]),
    .imem_stall    (in_vec[3]),
    .imem_done     (in_vec[4]),
    .dmem_req      (in_vec[5]),
    .dmem_stall    (in_vec[6]),
    .dmem_done     (in_vec[7]),
    .stall_pc      (stall_pc),
    .stall_ifid    (stall_ifid),
    .stall_idex    (stall_idex),
    .stall_exmem   (stall_exmem),
    .stall_memwb   (stall_memwb),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .flush_exmem   (flush_exmem),
    .flush_memwb   (flush_memwb),
    .fetch_discard (fetch_discard),
    .halted        (halted),
    .err           (err)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_lu_cnt   (perf_lu_cnt)
`endif
  );

  // Drive one cycle of stimulus and queue the outputs expected for it.
  task automatic drive(input logic [11:0] v, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] w, input logic [11:0] e, input string tag);
    @(negedge clk);
    in_vec = v;
    rs_r   = a;
    rt_r   = b;
    wr_r   = w;
    sb.push_back('{val: e, tag: tag});
    #2;
  endtask

  task automatic test_reset();
    logic [11:0] iv[3] = '{I_RST | I_BR | I_DRQ | I_DST | I_HID, I_RST, O_0};
    exp_t ent;
    for (int i = 0; i < 3; i++) begin
      drive(iv[i], 3'd0, 3'd0, 3'd0, O_0, $sformatf("reset[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
  endtask

  task automatic test_load_use();
    logic [11:0] iv[6] = '{I_MR | I_RSU, O_0, I_MR | I_RTU, I_MR | I_RSU | I_RTU,
                           I_MR | I_RTU, I_RSU};
    logic [2:0]  av[6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd3, 3'd3};
    logic [2:0]  bv[6] = '{3'd0, 3'd0, 3'd5, 3'd2, 3'd1, 3'd0};
    logic [2:0]  wv[6] = '{3'd3, 3'd0, 3'd5, 3'd4, 3'd3, 3'd3};
    logic [11:0] ev[6] = '{O_LU, O_0, O_LU, O_0, O_0, O_0};
    exp_t ent;
    for (int i = 0; i < 6; i++) begin
      drive(iv[i], av[i], bv[i], wv[i], ev[i], $sformatf("load_use[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
  endtask

  task automatic test_dmem_wait();
    logic [11:0] iv[6] = '{I_DRQ | I_DST, I_DRQ | I_DST, I_DRQ | I_DST | I_BR, I_DRQ | I_DST,
                           I_DRQ | I_DDN, I_BR};
    logic [11:0] ev[6] = '{O_DW, O_DW, O_DW, O_DW, O_0, O_BR};
    exp_t ent;
    for (int i = 0; i < 6; i++) begin
      drive(iv[i], 3'd0, 3'd0, 3'd0, ev[i], $sformatf("dmem_wait[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
  endtask

  task automatic test_fetch();
    logic [11:0] iv[19] = '{I_BR | I_IST, I_IST, I_IST, I_IDN, O_0,
                            I_IST, I_IST, I_IDN, O_0,
                            I_IST, I_BR, I_IDN, O_0,
                            I_IST, I_DRQ | I_DST, I_DDN, O_0, I_IDN, O_0};
    logic [11:0] ev[19] = '{O_BR, O_ID, O_ID, O_IDX, O_0,
                            O_IF, O_IF, O_0, O_0,
                            O_IF, O_BRW, O_IDX, O_0,
                            O_IF, O_DW, O_0, O_IF, O_0, O_0};
    exp_t ent;
    for (int i = 0; i < 19; i++) begin
      drive(iv[i], 3'd0, 3'd0, 3'd0, ev[i], $sformatf("fetch[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
  endtask

  task automatic test_halt();
    logic [11:0] iv[12] = '{I_HID, O_0, O_0, I_DRQ | I_DST, I_DDN, O_0, I_HWB, O_0,
                            I_BR | I_DRQ | I_DST | I_IST | I_IDN, I_RST, O_0, I_IST};
    logic [11:0] ev[12] = '{O_IF, O_IF, O_IF, O_DW, O_0, O_IF, O_HALT, O_HALT,
                            O_HALT, O_0, O_0, O_IF};
    exp_t ent;
    for (int i = 0; i < 12; i++) begin
      drive(iv[i], 3'd0, 3'd0, 3'd0, ev[i], $sformatf("halt[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
    drive(I_RST, 3'd0, 3'd0, 3'd0, O_0, "halt_cleanup");
    void'(sb.pop_front());
  endtask

  task automatic test_err();
    logic [11:0] iv[12] = '{I_DDN, O_0, O_0, I_RST, O_0, I_IDN, O_0, I_RST, O_0,
                            I_DRQ | I_DST | I_DDN, I_DDN, O_0};
    logic [11:0] ev[12] = '{O_0, O_ERR, O_ERR, O_0, O_0, O_0, O_ERR, O_0, O_0,
                            O_DW, O_0, O_0};
    exp_t ent;
    for (int i = 0; i < 12; i++) begin
      drive(iv[i], 3'd0, 3'd0, 3'd0, ev[i], $sformatf("err[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
  endtask

  // Entry cycle clears the counter; it reaches 64 after 64 DWAIT cycles and err
  // becomes visible the cycle after.
  task automatic test_watchdog();
    logic [11:0] v, e;
    exp_t ent;
    for (int i = 0; i < 70; i++) begin
      if (i <= 64) begin
        v = I_DRQ | I_DST; e = O_DW;
      end else if (i == 65) begin
        v = I_DRQ | I_DST; e = O_DW | O_ERR;
      end else if (i == 66) begin
        v = I_DRQ | I_DDN; e = O_ERR;
      end else if (i == 67) begin
        v = O_0; e = O_ERR;
      end else if (i == 68) begin
        v = I_RST; e = O_0;
      end else begin
        v = O_0; e = O_0;
      end
      drive(v, 3'd0, 3'd0, 3'd0, e, $sformatf("watchdog[%0d]", i));
      ent = sb.pop_front();
      total++;
      if (obs !== ent.val) begin
        bad++;
        $display("FAIL %s: got %b want %b", ent.tag, obs, ent.val);
      end
    end
  endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
  task automatic test_perf();
    logic [11:0] iv[5] = '{I_RST, I_MR | I_RSU, I_BR, I_IST, I_IDN};
    for (int i = 0; i < 5; i++) begin
      drive(iv[i], 3'd2, 3'd0, 3'd2, O_0, "perf");
      void'(sb.pop_front());
    end
    drive(O_0, 3'd0, 3'd0, 3'd0, O_0, "perf");
    void'(sb.pop_front());
    total++;
    if ({perf_stall_cyc, perf_flush_cnt, perf_lu_cnt} !== {16'd2, 16'd1, 16'd1}) begin
      bad++;
      $display("FAIL perf: got %0d/%0d/%0d want 2/1/1", perf_stall_cyc, perf_flush_cnt,
               perf_lu_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_fetch();
    test_halt();
    test_err();
    test_watchdog();
`ifdef PIPE_CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
